// File: rtl/seg7_pkg.sv
// Shared constants, FSM encoding and sizing helper for the seven-segment controller.
package seg7_pkg;

    // Segment patterns are {g,f,e,d,c,b,a}, logical (active-high) levels.
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_OFF  = 7'h00;

    // Font indexed by nibble value; element 15 is listed first.
    localparam logic [15:0][6:0] HEX_FONT = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} bcd_state_t;

    // BCD accumulator width: one nibble per decimal digit of 2^vw plus a spare,
    // digits = ceil(vw * log10(2)) computed in integer arithmetic.
    function automatic int bcd_w(input int vw);
        return 4 * (((vw * 302) + 999) / 1000 + 1);
    endfunction

endpackage

// File: rtl/seg7_bin2bcd.sv
// Sequential double-dabble converter: one value bit per cycle, then a one-cycle
// DONE strobe carrying the low digits and an overflow flag for the rest.
module seg7_bin2bcd
    import seg7_pkg::*;
#(
    parameter int VALUE_W    = 32,
    parameter int NUM_DIGITS = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [VALUE_W-1:0]         value,
    output logic                       busy,
    output logic                       done,
    output logic [NUM_DIGITS-1:0][3:0] digits,
    output logic                       ovf
);

    localparam int BCD_W = bcd_w(VALUE_W);
    localparam int CNT_W = $clog2(VALUE_W) + 1;
    localparam int EXT_W = BCD_W + 4 * NUM_DIGITS;

    bcd_state_t         state;
    logic [VALUE_W-1:0] bin;
    logic [BCD_W-1:0]   bcd;
    logic [BCD_W-1:0]   adj;
    logic [CNT_W-1:0]   cnt;
    logic [EXT_W-1:0]   ext;

    // Add-3 correction on every nibble that would exceed 9 after doubling.
    always_comb begin
        adj = bcd;
        for (int i = 0; i < BCD_W / 4; i++) begin
            if (bcd[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    // Conversion FSM: latch, shift VALUE_W times, then present the result for one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            bin   <= '0;
            bcd   <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    bin   <= value;
                    bcd   <= '0;
                    cnt   <= '0;
                    state <= SHIFT;
                end
                SHIFT: begin
                    bcd <= (adj << 1) | BCD_W'(bin[VALUE_W-1]);
                    bin <= bin << 1;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(VALUE_W - 1))
                        state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Zero-extend so small VALUE_W with many digits still slices cleanly.
    assign ext    = {{(4 * NUM_DIGITS){1'b0}}, bcd};
    assign digits = ext[4*NUM_DIGITS-1:0];
    assign ovf    = |ext[EXT_W-1:4*NUM_DIGITS];
    assign busy   = (state != IDLE);
    assign done   = (state == DONE);

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed seven-segment controller: display register, digit scan,
// leading-zero blanking and registered, polarity-adjusted pin drivers.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS  = 8,
    parameter int VALUE_W     = 32,
    parameter int REFRESH_DIV = 100000,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [VALUE_W-1:0]    value,
    input  logic                  load,
    input  logic                  mode,
    input  logic                  blank_lz,
    input  logic [NUM_DIGITS-1:0] dp_mask,
    input  logic                  enable,
    output logic                  busy,
    output logic [6:0]            seg_o,
    output logic                  dp_o,
    output logic [NUM_DIGITS-1:0] an_o
);

    localparam int   IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int   CNT_W = $clog2(REFRESH_DIV);
    localparam int   VEXT_W = VALUE_W + 4 * NUM_DIGITS;
    localparam logic POL   = (ACTIVE_LOW != 0);

    logic [NUM_DIGITS-1:0][3:0] disp;
    logic                       disp_ovf;
    logic                       disp_blz;
    logic                       blz_pend;
    logic [CNT_W-1:0]           pres;
    logic [IDX_W-1:0]           idx;

    logic                       accept;
    logic                       bcd_done;
    logic                       bcd_ovf;
    logic [NUM_DIGITS-1:0][3:0] bcd_digits;
    logic [VEXT_W-1:0]          vext;
    logic                       upper_zero;
    logic                       blanked;
    logic [NUM_DIGITS-1:0]      onehot;
    logic [6:0]                 nseg;
    logic                       ndp;
    logic [NUM_DIGITS-1:0]      nan;

    assign accept = load & ~busy;
    assign vext   = {{(4 * NUM_DIGITS){1'b0}}, value};

    seg7_bin2bcd #(
        .VALUE_W    (VALUE_W),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_bin2bcd (
        .clk    (clk),
        .reset  (reset),
        .start  (accept & mode),
        .value  (value),
        .busy   (busy),
        .done   (bcd_done),
        .digits (bcd_digits),
        .ovf    (bcd_ovf)
    );

    // Display register: hex loads land immediately, decimal ones when the converter finishes.
    // blank_lz of a decimal load is held back so it switches together with the digits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            disp     <= '0;
            disp_ovf <= 1'b0;
            disp_blz <= 1'b0;
            blz_pend <= 1'b0;
        end else if (bcd_done) begin
            disp     <= bcd_digits;
            disp_ovf <= bcd_ovf;
            disp_blz <= blz_pend;
        end else if (accept) begin
            if (mode) begin
                blz_pend <= blank_lz;
            end else begin
                disp     <= vext[4*NUM_DIGITS-1:0];
                disp_ovf <= |vext[VEXT_W-1:4*NUM_DIGITS];
                disp_blz <= blank_lz;
            end
        end
    end

    // Prescaler and digit index; both freeze while the display is disabled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pres <= '0;
            idx  <= '0;
        end else if (enable) begin
            if (pres == CNT_W'(REFRESH_DIV - 1)) begin
                pres <= '0;
                idx  <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
            end else begin
                pres <= pres + 1'b1;
            end
        end
    end

    // A digit is a leading zero when it and every digit to its left are zero.
    always_comb begin
        upper_zero = 1'b1;
        for (int j = 0; j < NUM_DIGITS; j++) begin
            if (j >= int'(idx) && disp[j] != 4'h0)
                upper_zero = 1'b0;
        end
    end

    assign blanked = disp_blz && (idx != '0) && upper_zero;
    assign onehot  = NUM_DIGITS'(1) << idx;

    // Logical-level pattern for the digit currently selected.
    always_comb begin
        nseg = SEG_OFF;
        ndp  = 1'b0;
        nan  = '0;
        if (enable) begin
            if (disp_ovf) begin
                nseg = SEG_DASH;
                nan  = onehot;
            end else if (!blanked) begin
                nseg = HEX_FONT[disp[idx]];
                ndp  = dp_mask[idx];
                nan  = onehot;
            end
        end
    end

    // Pin registers; reset forces every driver inactive without waiting for a clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg_o <= {7{POL}};
            dp_o  <= POL;
            an_o  <= {NUM_DIGITS{POL}};
        end else begin
            seg_o <= nseg ^ {7{POL}};
            dp_o  <= ndp ^ POL;
            an_o  <= nan ^ {NUM_DIGITS{POL}};
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Randomized self-checking bench for seg7_scan_ctrl with an arithmetic reference model.
module tb_seg7_scan_ctrl;

    localparam int ND = 4;
    localparam int VW = 16;
    localparam int RD = 4;

    logic          clk;
    logic          reset;
    logic [VW-1:0] value;
    logic          load;
    logic          mode;
    logic          blank_lz;
    logic [ND-1:0] dp_mask;
    logic          enable;
    logic          busy;
    logic [6:0]    seg_o;
    logic          dp_o;
    logic [ND-1:0] an_o;

    seg7_scan_ctrl #(
        .NUM_DIGITS  (ND),
        .VALUE_W     (VW),
        .REFRESH_DIV (RD),
        .ACTIVE_LOW  (1)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .value    (value),
        .load     (load),
        .mode     (mode),
        .blank_lz (blank_lz),
        .dp_mask  (dp_mask),
        .enable   (enable),
        .busy     (busy),
        .seg_o    (seg_o),
        .dp_o     (dp_o),
        .an_o     (an_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [6:0] font [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Reference model: what number is on display, in which base, and how many
    // enabled cycles have elapsed (the lit digit follows from that count).
    int          en_cyc;
    int          busy_cnt;
    int unsigned num;
    int unsigned pend;
    int unsigned base;
    bit          m_ovf;
    bit          m_blz;
    bit          pend_blz;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got=%h expected=%h", tag, $time, got, exp);
        end
    endtask

    function automatic int unsigned pw(input int unsigned b, input int k);
        int unsigned r = 1;
        for (int i = 0; i < k; i++) r = r * b;
        return r;
    endfunction

    task automatic model_reset();
        en_cyc   = 0;
        busy_cnt = 0;
        num      = 0;
        base     = 16;
        m_ovf    = 1'b0;
        m_blz    = 1'b0;
    endtask

    // One clock: predict pins from pre-edge state and inputs, clock, advance model, compare.
    task automatic step();
        logic [6:0]    es;
        logic [ND-1:0] ea;
        logic [ND-1:0] oh;
        logic          ed;
        int            k;
        int unsigned   d;
        es = 7'h7F;
        ea = '1;
        ed = 1'b1;
        if (!reset && enable) begin
            k  = (en_cyc / RD) % ND;
            oh = ND'(1) << k;
            if (m_ovf) begin
                es = ~7'h40;
                ea = ~oh;
            end else if (!(m_blz && k > 0 && num < pw(base, k))) begin
                d  = (num / pw(base, k)) % base;
                es = ~font[d];
                ea = ~oh;
                ed = ~dp_mask[k];
            end
        end
        @(posedge clk);
        if (reset) begin
            model_reset();
        end else begin
            if (enable) en_cyc++;
            if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) begin
                    num   = pend;
                    base  = 10;
                    m_ovf = (pend > 9999);
                    m_blz = pend_blz;
                end
            end else if (load) begin
                if (mode) begin
                    busy_cnt = VW + 1;
                    pend     = 32'(value);
                    pend_blz = blank_lz;
                end else begin
                    num   = 32'(value);
                    base  = 16;
                    m_ovf = 1'b0;
                    m_blz = blank_lz;
                end
            end
        end
        #1;
        chk("seg", 32'(seg_o), 32'(es));
        chk("an", 32'(an_o), 32'(ea));
        chk("dp", 32'(dp_o), 32'(ed));
        chk("busy", 32'(busy), 32'(busy_cnt > 0));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pulse_load(input logic [VW-1:0] v, input logic m, input logic b);
        value    = v;
        mode     = m;
        blank_lz = b;
        load     = 1'b1;
        step();
        load     = 1'b0;
    endtask

    // Asynchronous reset between edges: pins must drop without a clock.
    task automatic async_reset();
        #2;
        reset = 1'b1;
        #1;
        chk("rst_seg", 32'(seg_o), 32'h7F);
        chk("rst_an", 32'(an_o), 32'hF);
        chk("rst_dp", 32'(dp_o), 32'h1);
        chk("rst_busy", 32'(busy), 32'h0);
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        value    = '0;
        load     = 1'b0;
        mode     = 1'b0;
        blank_lz = 1'b0;
        dp_mask  = '0;
        enable   = 1'b1;
        model_reset();
        step();
        step();
        reset = 1'b0;
        run(10);

        // Hex value, reset mid-scan and mid-conversion, then a full scan of 1A3F.
        pulse_load(16'h1A3F, 1'b0, 1'b0);
        run(6);
        async_reset();
        run(6);
        pulse_load(16'd777, 1'b1, 1'b0);
        run(5);
        async_reset();
        run(6);
        pulse_load(16'h1A3F, 1'b0, 1'b0);
        run(20);

        // Decimal 1234 with a second load ignored while busy.
        pulse_load(16'd1234, 1'b1, 1'b0);
        run(5);
        pulse_load(16'd9999, 1'b1, 1'b1);
        run(30);

        // Decimal overflow shows dashes.
        pulse_load(16'd12345, 1'b1, 1'b0);
        run(34);

        // Leading-zero blanking, including an all-zero value.
        pulse_load(16'h0007, 1'b0, 1'b1);
        run(17);
        pulse_load(16'h0000, 1'b0, 1'b1);
        run(17);
        pulse_load(16'd50, 1'b1, 1'b1);
        run(34);

        // Decimal point on digit 2, then freeze and resume the scan.
        dp_mask = 4'b0100;
        pulse_load(16'h1A3F, 1'b0, 1'b0);
        run(17);
        enable = 1'b0;
        run(10);
        enable = 1'b1;
        run(17);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            value    = VW'($urandom);
            mode     = 1'($urandom);
            blank_lz = 1'($urandom);
            load     = ($urandom_range(0, 7) == 0);
            enable   = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 15) == 0) dp_mask = ND'($urandom);
            if ($urandom_range(0, 3) == 0) value = VW'($urandom_range(0, 300));
            if (i == 200) async_reset();
            step();
        end
        load   = 1'b0;
        enable = 1'b1;
        run(40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Parametrised multiplexed seven-segment display controller. It captures a binary value on a load strobe and shows it as hexadecimal or decimal across `NUM_DIGITS` time-multiplexed digits. Decimal values are converted by a sequential double-dabble engine. Extra features are leading-zero blanking, per-digit decimal points, overflow indication and selectable output polarity. It sits between the core's memory-mapped output register and the board's segment/anode pins.

## Interface
- `NUM_DIGITS`, 8: digits driven (2..8).
- `VALUE_W`, 32: width of the binary input value.
- `REFRESH_DIV`, 100000: clock cycles each digit stays lit (≥2).
- `ACTIVE_LOW`, 1: 1 = segments, decimal point and anodes are driven active-low; 0 = active-high.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `value` in VALUE_W: value to display.
- `load` in 1: capture `value`, `mode` and `blank_lz` this cycle.
- `mode` in 1: 0 = hex, 1 = decimal.
- `blank_lz` in 1: blank leading zeros.
- `dp_mask` in NUM_DIGITS: decimal point per digit, bit 0 = rightmost digit; sampled live, not latched.
- `enable` in 1: 0 turns off all anodes.
- `busy` out 1: a conversion is in progress.
- `seg_o` out 7: {g,f,e,d,c,b,a}.
- `dp_o` out 1: decimal point.
- `an_o` out NUM_DIGITS: anode select, bit 0 = rightmost digit.

## Operation
- **Display register.** Holds `NUM_DIGITS` nibbles plus an overflow flag and a latched `blank_lz`. Reset value is all zero.
- **Load.**
  - `load` is honoured only when `busy`=0. A `load` while `busy`=1 is ignored and has no effect.
- **Hex mode.**
  - Nibble i = `value[4i+3:4i]`, zero-extended where `VALUE_W` < 4·NUM_DIGITS.
  - Overflow = any nonzero bit of `value` above bit 4·NUM_DIGITS−1.
- **Decimal mode.** Handled by a double-dabble FSM:
  - IDLE: on `load` with `mode`=1, latch `value`, clear the BCD accumulator (BCD_W = 4·(⌈VALUE_W·0.302⌉+1) bits) and go to SHIFT. `busy` rises.
  - SHIFT: each cycle, add 3 to every BCD nibble ≥5, then shift left one bit with the next value MSB shifted in. This runs for exactly VALUE_W cycles, then go to DONE.
  - DONE: for one cycle, write the low `NUM_DIGITS` BCD nibbles to the display register. Overflow = any higher BCD nibble nonzero. Return to IDLE and drop `busy`.
- **Scan.**
  - The prescaler counts 0..REFRESH_DIV−1.
  - At the terminal count the digit index increments modulo NUM_DIGITS (wraps from NUM_DIGITS−1 to 0).
  - `enable`=0 holds the prescaler and index and drives all anodes inactive.
- **Per-digit output for index k (logical levels, before polarity).**
  - Overflow set: `seg_o` = 7'h40 (dash) on every digit, `dp_o` off.
  - Otherwise, digit k blanked: `seg_o` = 0 and its anode is inactive. Digit k is blanked when latched `blank_lz`=1, k>0, and every nibble at positions ≥k is 0. Digit 0 is never blanked.
  - Otherwise: `seg_o` = hex font of nibble k, `dp_o` = `dp_mask[k]`, and `an_o` is one-hot at k.
  - Hex font 0–F: 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71.
- **Polarity.** When `ACTIVE_LOW`=1, `seg_o`, `dp_o` and `an_o` are bitwise inverted.

## Timing
- **Reset.** While `reset` is asserted, outputs go immediately to all-inactive:
  - `seg_o` off, `dp_o` off, `an_o` all inactive. With `ACTIVE_LOW`=1 that is 7'h7F, 1 and all-ones.
  - `busy`=0, prescaler=0, index=0, FSM in IDLE.
- **Reset mid-conversion.** Aborts the conversion. The display register returns to zero.
- **Hex load.** `load` at edge n updates the display register at edge n+1. The outputs show the new nibble at edge n+2.
- **Decimal load.**
  - `busy` is high from edge n+1 through the DONE cycle: VALUE_W+1 cycles in total.
  - The display register updates at the end of DONE. Outputs follow one cycle later.
- **Outputs.** `seg_o`, `dp_o` and `an_o` are all registered, one cycle after the index changes. Each digit is lit for exactly REFRESH_DIV cycles.
- **Simultaneous events.** An index wrap coinciding with a display-register update uses the new contents at the next output register update. There is no tearing within a digit.

## Structure
- Package `seg7_pkg`:
  - hex font constant array, `SEG_DASH` = 7'h40, `SEG_OFF` = 7'h00;
  - FSM state enum {IDLE, SHIFT, DONE};
  - function computing BCD_W from VALUE_W.
- Sub-module `seg7_bin2bcd` holds the double-dabble FSM and its overflow output.
- The top level holds the display register, prescaler, scan index, blanking logic and output registers.

## Test plan
Scenarios use NUM_DIGITS=4, VALUE_W=16, REFRESH_DIV=4, ACTIVE_LOW=1.
- **Reset.** Assert `reset` asynchronously mid-scan → `seg_o`=7F, `an_o`=F and `busy`=0 immediately; the index restarts at 0 after release.
- **Hex load.** `value`=16'h1A3F, `mode`=0 → digits 0..3 show 71, 4F, 77, 06 in turn. Each `an_o` pattern (E, D, B, 7) holds 4 cycles, then wraps to digit 0.
- **Decimal load.** `value`=1234, `mode`=1 → `busy` high for exactly 17 cycles, then digits show 4, 3, 2, 1. A second `load` issued during `busy` is ignored.
- **Decimal overflow.** `value`=16'd12345 in decimal → every digit shows dash (`seg_o`=7'h3F after inversion).
- **Leading-zero blanking.** `blank_lz`=1, `value`=7, hex → digit 0 shows 07. Digits 1–3 have `an_o` inactive. `value`=0 keeps digit 0 lit showing 0.
- **Decimal point and enable.** `dp_mask`=4'b0100 → `dp_o` is low only while digit 2 is lit. `enable`=0 → `an_o`=F and the index is frozen. Re-enabling resumes from the frozen index.
